// File: rtl/axi_sram_slave.sv
// AXI4 slave serving one INCR/FIXED burst at a time from an on-chip SRAM array.
// Optional macro AXI_SLAVE_WRAP_EN enables WRAP bursts; without it WRAP is treated as INCR.
module axi_sram_slave #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   SAXI_awid,
  input  logic [ADDR_W-1:0] SAXI_awaddr,
  input  logic [7:0]        SAXI_awlen,
  input  logic [2:0]        SAXI_awsize,
  input  logic [1:0]        SAXI_awburst,
  input  logic              SAXI_awvalid,
  output logic              SAXI_awready,
  input  logic [DATA_W-1:0] SAXI_wdata,
  input  logic [DATA_W/8-1:0] SAXI_wstrb,
  input  logic              SAXI_wlast,
  input  logic              SAXI_wvalid,
  output logic              SAXI_wready,
  output logic [ID_W-1:0]   SAXI_bid,
  output logic [1:0]        SAXI_bresp,
  output logic              SAXI_bvalid,
  input  logic              SAXI_bready,
  input  logic [ID_W-1:0]   SAXI_arid,
  input  logic [ADDR_W-1:0] SAXI_araddr,
  input  logic [7:0]        SAXI_arlen,
  input  logic [2:0]        SAXI_arsize,
  input  logic [1:0]        SAXI_arburst,
  input  logic              SAXI_arvalid,
  output logic              SAXI_arready,
  output logic [ID_W-1:0]   SAXI_rid,
  output logic [DATA_W-1:0] SAXI_rdata,
  output logic [1:0]        SAXI_rresp,
  output logic              SAXI_rlast,
  output logic              SAXI_rvalid,
  input  logic              SAXI_rready
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * STRB_W);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t            state;
  logic              rr_rd;
  logic              grant_rd;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              burst_err;
  logic              size_err;
  logic              beat_err;
  logic              wlast_err;
  logic              last_beat;
  logic              w_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] addr_incr;
  logic [ADDR_W-1:0] next_addr;
`ifdef AXI_SLAVE_WRAP_EN
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_base;
`endif

  assign SAXI_arready = (state == IDLE) & grant_rd;
  assign SAXI_awready = (state == IDLE) & ~grant_rd;
  assign SAXI_wready  = wready_q;
  assign SAXI_bvalid  = bvalid_q;
  assign SAXI_bresp   = bresp_q;
  assign SAXI_bid     = id_q;
  assign SAXI_rvalid  = rvalid_q;
  assign SAXI_rdata   = rdata_q;
  assign SAXI_rresp   = rresp_q;
  assign SAXI_rlast   = rlast_q;
  assign SAXI_rid     = id_q;

  // Range check on the offset form so a window ending at 2^ADDR_W cannot overflow.
  assign offset    = addr_q - BASE_ADDR;
  assign in_range  = (addr_q >= BASE_ADDR) && (offset < MEM_BYTES);
  assign mem_idx   = offset[SIZE_MAX +: IDX_W];
  assign last_beat = (cnt_q == len_q);
  assign size_err  = (size_q > 3'(SIZE_MAX));
`ifdef AXI_SLAVE_WRAP_EN
  assign burst_err = (burst_q == 2'b11) ||
                     ((burst_q == 2'b10) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
`else
  assign burst_err = (burst_q == 2'b11);
`endif
  assign beat_err  = ~in_range | burst_err | size_err;
  assign wlast_err = (SAXI_wlast != last_beat);
  assign w_fire    = (state == WR) & wready_q & SAXI_wvalid;
  assign mem_we    = w_fire & ~beat_err & ~wlast_err;

  always_comb begin
    addr_incr = addr_q + (ADDR_W'(1) << size_q);
    next_addr = addr_incr;
`ifdef AXI_SLAVE_WRAP_EN
    wrap_bytes = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
    wrap_base  = addr_q & ~(wrap_bytes - ADDR_W'(1));
`endif
    case (burst_q)
      2'b00: next_addr = addr_q;
`ifdef AXI_SLAVE_WRAP_EN
      2'b10: if ((addr_incr - wrap_base) >= wrap_bytes) next_addr = wrap_base;
`endif
      default: ;
    endcase
  end

  // rr_rd only flips when a grant is made against a competing request, so a lone
  // request never disturbs the fairness order between contended transactions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_rd    <= 1'b1;
      grant_rd <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (SAXI_arvalid && SAXI_arready) begin
            id_q    <= SAXI_arid;
            addr_q  <= SAXI_araddr;
            len_q   <= SAXI_arlen;
            size_q  <= SAXI_arsize;
            burst_q <= SAXI_arburst;
            cnt_q   <= '0;
            state   <= RD;
            if (SAXI_awvalid) rr_rd <= 1'b0;
          end else if (SAXI_awvalid && SAXI_awready) begin
            id_q     <= SAXI_awid;
            addr_q   <= SAXI_awaddr;
            len_q    <= SAXI_awlen;
            size_q   <= SAXI_awsize;
            burst_q  <= SAXI_awburst;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wready_q <= 1'b1;
            state    <= WR;
            if (SAXI_arvalid) rr_rd <= 1'b1;
          end else if (SAXI_arvalid && SAXI_awvalid) begin
            grant_rd <= rr_rd;
          end else if (SAXI_arvalid) begin
            grant_rd <= 1'b1;
          end else if (SAXI_awvalid) begin
            grant_rd <= 1'b0;
          end
        end
        RD: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= beat_err ? '0 : mem[mem_idx];
            rresp_q  <= beat_err ? 2'b10 : 2'b00;
            rlast_q  <= last_beat;
          end else if (SAXI_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (last_beat) begin
              state    <= IDLE;
              grant_rd <= rr_rd;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q + 8'd1;
            end
          end
        end
        WR: begin
          if (w_fire) begin
            err_q <= err_q | beat_err | wlast_err;
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q | beat_err | wlast_err) ? 2'b10 : 2'b00;
              state    <= WRESP;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q + 8'd1;
            end
          end
        end
        WRESP: begin
          if (SAXI_bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
            grant_rd <= rr_rd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is left unreset so it maps onto block RAM and survives a reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (SAXI_wstrb[b]) mem[mem_idx][8*b +: 8] <= SAXI_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave; WRAP expectations follow AXI_SLAVE_WRAP_EN.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
  localparam int MEM_WORDS = 4096;
  localparam int TMO = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  SAXI_awid = '0;
  logic [31:0] SAXI_awaddr = '0;
  logic [7:0]  SAXI_awlen = '0;
  logic [2:0]  SAXI_awsize = '0;
  logic [1:0]  SAXI_awburst = '0;
  logic        SAXI_awvalid = 1'b0;
  logic        SAXI_awready;
  logic [63:0] SAXI_wdata = '0;
  logic [7:0]  SAXI_wstrb = '0;
  logic        SAXI_wlast = 1'b0;
  logic        SAXI_wvalid = 1'b0;
  logic        SAXI_wready;
  logic [3:0]  SAXI_bid;
  logic [1:0]  SAXI_bresp;
  logic        SAXI_bvalid;
  logic        SAXI_bready = 1'b0;
  logic [3:0]  SAXI_arid = '0;
  logic [31:0] SAXI_araddr = '0;
  logic [7:0]  SAXI_arlen = '0;
  logic [2:0]  SAXI_arsize = '0;
  logic [1:0]  SAXI_arburst = '0;
  logic        SAXI_arvalid = 1'b0;
  logic        SAXI_arready;
  logic [3:0]  SAXI_rid;
  logic [63:0] SAXI_rdata;
  logic [1:0]  SAXI_rresp;
  logic        SAXI_rlast;
  logic        SAXI_rvalid;
  logic        SAXI_rready = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;
  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t rq[$];
  bexp_t  bq[$];
  logic [63:0] mm [int];

  axi_sram_slave dut (
    .clock(clock), .reset(reset),
    .SAXI_awid(SAXI_awid), .SAXI_awaddr(SAXI_awaddr), .SAXI_awlen(SAXI_awlen),
    .SAXI_awsize(SAXI_awsize), .SAXI_awburst(SAXI_awburst),
    .SAXI_awvalid(SAXI_awvalid), .SAXI_awready(SAXI_awready),
    .SAXI_wdata(SAXI_wdata), .SAXI_wstrb(SAXI_wstrb), .SAXI_wlast(SAXI_wlast),
    .SAXI_wvalid(SAXI_wvalid), .SAXI_wready(SAXI_wready),
    .SAXI_bid(SAXI_bid), .SAXI_bresp(SAXI_bresp), .SAXI_bvalid(SAXI_bvalid),
    .SAXI_bready(SAXI_bready),
    .SAXI_arid(SAXI_arid), .SAXI_araddr(SAXI_araddr), .SAXI_arlen(SAXI_arlen),
    .SAXI_arsize(SAXI_arsize), .SAXI_arburst(SAXI_arburst),
    .SAXI_arvalid(SAXI_arvalid), .SAXI_arready(SAXI_arready),
    .SAXI_rid(SAXI_rid), .SAXI_rdata(SAXI_rdata), .SAXI_rresp(SAXI_rresp),
    .SAXI_rlast(SAXI_rlast), .SAXI_rvalid(SAXI_rvalid), .SAXI_rready(SAXI_rready)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                            input int size, input logic [1:0] burst,
                                            input int i);
    logic [31:0] sz;
`ifdef AXI_SLAVE_WRAP_EN
    logic [31:0] wb;
    logic [31:0] base;
`endif
    sz = 32'd1 << size;
    if (burst == 2'b00) return a;
`ifdef AXI_SLAVE_WRAP_EN
    if (burst == 2'b10) begin
      wb   = 32'(len + 1) * sz;
      base = a - (a % wb);
      return base + ((a - base + 32'(i) * sz) % wb);
    end
`endif
    return a + 32'(i) * sz;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input int len, input int size,
                                   input logic [1:0] burst);
    bit e;
    e = (a < BASE_ADDR) || (64'(a) >= 64'(BASE_ADDR) + 64'(MEM_WORDS * 8));
    e = e || (burst == 2'b11) || (size > 3);
`ifdef AXI_SLAVE_WRAP_EN
    e = e || ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
`endif
    return e;
  endfunction

  task automatic expect_read(input logic [3:0] id, input logic [31:0] a, input int len,
                             input int size, input logic [1:0] burst);
    logic [31:0] ba;
    rbeat_t r;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, len, size, burst, i);
      r.id = id;
      r.last = (i == len);
      if (model_err(ba, len, size, burst)) begin
        r.data = '0;
        r.resp = 2'b10;
      end else begin
        r.data = mm[int'((ba - BASE_ADDR) >> 3)];
        r.resp = 2'b00;
      end
      rq.push_back(r);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input int len,
                         input int size, input logic [1:0] burst);
    int n;
    @(negedge clock);
    SAXI_arid = id; SAXI_araddr = a; SAXI_arlen = 8'(len);
    SAXI_arsize = 3'(size); SAXI_arburst = burst; SAXI_arvalid = 1'b1;
    n = 0;
    while (!SAXI_arready && n < TMO) begin @(negedge clock); n++; end
    checks++;
    if (!SAXI_arready) begin
      errors++;
      $display("[TB] FAIL ar_handshake: arready=%b after %0d cycles, required 1", SAXI_arready, n);
    end
    @(posedge clock); #1 SAXI_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input int len,
                         input int size, input logic [1:0] burst);
    int n;
    @(negedge clock);
    SAXI_awid = id; SAXI_awaddr = a; SAXI_awlen = 8'(len);
    SAXI_awsize = 3'(size); SAXI_awburst = burst; SAXI_awvalid = 1'b1;
    n = 0;
    while (!SAXI_awready && n < TMO) begin @(negedge clock); n++; end
    checks++;
    if (!SAXI_awready) begin
      errors++;
      $display("[TB] FAIL aw_handshake: awready=%b after %0d cycles, required 1", SAXI_awready, n);
    end
    @(posedge clock); #1 SAXI_awvalid = 1'b0;
  endtask

  task automatic write_beats(input logic [3:0] id, input logic [31:0] a, input int len,
                             input int size, input logic [1:0] burst, input logic [63:0] data0,
                             input logic [7:0] strb, input bit bad_wlast);
    bit acc, e, wl;
    logic [31:0] ba;
    logic [63:0] d, w;
    int k, n;
    bexp_t b;
    acc = 1'b0;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, len, size, burst, i);
      wl = bad_wlast ? (i == 0) : (i == len);
      d  = data0 * 64'(i + 1);
      e  = model_err(ba, len, size, burst) || (wl != (i == len));
      acc = acc || e;
      if (!e) begin
        k = int'((ba - BASE_ADDR) >> 3);
        w = mm.exists(k) ? mm[k] : 64'hx;
        for (int j = 0; j < 8; j++) if (strb[j]) w[8*j +: 8] = d[8*j +: 8];
        mm[k] = w;
      end
      @(negedge clock);
      SAXI_wdata = d; SAXI_wstrb = strb; SAXI_wlast = wl; SAXI_wvalid = 1'b1;
      n = 0;
      while (!SAXI_wready && n < TMO) begin @(negedge clock); n++; end
      checks++;
      if (!SAXI_wready) begin
        errors++;
        $display("[TB] FAIL w_handshake beat %0d: wready=%b, required 1", i, SAXI_wready);
      end
      @(posedge clock); #1 SAXI_wvalid = 1'b0; SAXI_wlast = 1'b0;
    end
    b.resp = acc ? 2'b10 : 2'b00;
    b.id = id;
    bq.push_back(b);
  endtask

  task automatic collect_b();
    int n;
    bexp_t b;
    @(negedge clock);
    SAXI_bready = 1'b1;
    n = 0;
    while (!SAXI_bvalid && n < TMO) begin @(negedge clock); n++; end
    checks++;
    if (!SAXI_bvalid || bq.size() == 0) begin
      errors++;
      $display("[TB] FAIL b_wait: bvalid=%b pending=%0d, required bvalid 1", SAXI_bvalid, bq.size());
      bq.delete();
    end else begin
      b = bq.pop_front();
      checks++;
      if (SAXI_bresp !== b.resp) begin
        errors++;
        $display("[TB] FAIL bresp: got %b, required %b", SAXI_bresp, b.resp);
      end
      checks++;
      if (SAXI_bid !== b.id) begin
        errors++;
        $display("[TB] FAIL bid: got %h, required %h", SAXI_bid, b.id);
      end
    end
    @(posedge clock); #1 SAXI_bready = 1'b0;
  endtask

  task automatic collect_r(input int hold);
    int n;
    rbeat_t r;
    logic [63:0] d0;
    while (rq.size() > 0) begin
      @(negedge clock);
      n = 0;
      while (!SAXI_rvalid && n < TMO) begin @(negedge clock); n++; end
      checks++;
      if (!SAXI_rvalid) begin
        errors++;
        $display("[TB] FAIL r_wait: rvalid=%b after %0d cycles, required 1", SAXI_rvalid, n);
        rq.delete();
        return;
      end
      r = rq.pop_front();
      if (hold > 0) begin
        d0 = SAXI_rdata;
        for (int k = 0; k < hold; k++) begin
          @(negedge clock);
          checks++;
          if (SAXI_rdata !== d0 || SAXI_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rdata_hold: got %h valid %b, required %h valid 1", SAXI_rdata, SAXI_rvalid, d0);
          end
        end
        hold = 0;
      end
      SAXI_rready = 1'b1;
      checks++;
      if (SAXI_rdata !== r.data) begin
        errors++;
        $display("[TB] FAIL rdata: got %h, required %h", SAXI_rdata, r.data);
      end
      checks++;
      if (SAXI_rresp !== r.resp) begin
        errors++;
        $display("[TB] FAIL rresp: got %b, required %b", SAXI_rresp, r.resp);
      end
      checks++;
      if (SAXI_rlast !== r.last) begin
        errors++;
        $display("[TB] FAIL rlast: got %b, required %b", SAXI_rlast, r.last);
      end
      checks++;
      if (SAXI_rid !== r.id) begin
        errors++;
        $display("[TB] FAIL rid: got %h, required %h", SAXI_rid, r.id);
      end
      @(posedge clock); #1 SAXI_rready = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks += 5;
    if (SAXI_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b, required 0", SAXI_rvalid); end
    if (SAXI_bvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bvalid: got %b, required 0", SAXI_bvalid); end
    if (SAXI_wready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wready: got %b, required 0", SAXI_wready); end
    if (SAXI_arready !== 1'b1) begin errors++; $display("[TB] FAIL reset_arready: got %b, required 1", SAXI_arready); end
    if (SAXI_awready !== 1'b0) begin errors++; $display("[TB] FAIL reset_awready: got %b, required 0", SAXI_awready); end
    reset = 1'b1;
  endtask

  task automatic test_incr_burst();
    send_aw(4'h3, BASE_ADDR, 3, 3, 2'b01);
    write_beats(4'h3, BASE_ADDR, 3, 3, 2'b01, 64'h11, 8'hFF, 1'b0);
    collect_b();
    expect_read(4'h5, BASE_ADDR, 3, 3, 2'b01);
    send_ar(4'h5, BASE_ADDR, 3, 3, 2'b01);
    collect_r(0);
  endtask

  task automatic test_strobe();
    send_aw(4'h1, BASE_ADDR, 0, 3, 2'b01);
    write_beats(4'h1, BASE_ADDR, 0, 3, 2'b01, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b0);
    collect_b();
    expect_read(4'h1, BASE_ADDR, 0, 3, 2'b01);
    send_ar(4'h1, BASE_ADDR, 0, 3, 2'b01);
    collect_r(0);
  endtask

  task automatic test_out_of_range();
    expect_read(4'h2, 32'h7FFF_FFF8, 1, 3, 2'b01);
    send_ar(4'h2, 32'h7FFF_FFF8, 1, 3, 2'b01);
    collect_r(0);
  endtask

  task automatic test_mid_burst_reset();
    int n;
    send_ar(4'h4, BASE_ADDR, 3, 3, 2'b01);
    @(negedge clock);
    n = 0;
    while (!SAXI_rvalid && n < TMO) begin @(negedge clock); n++; end
    reset = 1'b0;
    #1;
    checks++;
    if (SAXI_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rvalid: got %b, required 0", SAXI_rvalid); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    expect_read(4'h6, BASE_ADDR, 0, 3, 2'b01);
    @(negedge clock);
    SAXI_arid = 4'h6; SAXI_araddr = BASE_ADDR; SAXI_arlen = 8'd0;
    SAXI_arsize = 3'd3; SAXI_arburst = 2'b01; SAXI_arvalid = 1'b1;
    #1;
    checks++;
    if (SAXI_arready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_arready: got %b, required 1", SAXI_arready); end
    @(posedge clock); #1 SAXI_arvalid = 1'b0;
    collect_r(0);
  endtask

  task automatic test_arbitration();
    int n;
    pulse_reset();
    @(negedge clock);
    SAXI_arid = 4'h7; SAXI_araddr = BASE_ADDR + 32'h8; SAXI_arlen = 8'd0;
    SAXI_arsize = 3'd3; SAXI_arburst = 2'b01; SAXI_arvalid = 1'b1;
    SAXI_awid = 4'h8; SAXI_awaddr = BASE_ADDR + 32'h30; SAXI_awlen = 8'd0;
    SAXI_awsize = 3'd3; SAXI_awburst = 2'b01; SAXI_awvalid = 1'b1;
    #1;
    checks++;
    if (SAXI_arready !== 1'b1 || SAXI_awready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arb_first: arready=%b awready=%b, required 1 0", SAXI_arready, SAXI_awready);
    end
    expect_read(4'h7, BASE_ADDR + 32'h8, 0, 3, 2'b01);
    @(posedge clock); #1 SAXI_arvalid = 1'b0;
    collect_r(5);
    n = 0;
    while (!SAXI_awready && n < TMO) begin @(negedge clock); n++; end
    checks++;
    if (!SAXI_awready) begin errors++; $display("[TB] FAIL arb_then_write: awready=%b, required 1", SAXI_awready); end
    @(posedge clock); #1 SAXI_awvalid = 1'b0;
    write_beats(4'h8, BASE_ADDR + 32'h30, 0, 3, 2'b01, 64'hCAFE_0000_1234_5678, 8'hFF, 1'b0);
    collect_b();

    @(negedge clock);
    SAXI_arid = 4'h9; SAXI_araddr = BASE_ADDR + 32'h38; SAXI_arvalid = 1'b1;
    SAXI_awid = 4'hA; SAXI_awaddr = BASE_ADDR + 32'h38; SAXI_awvalid = 1'b1;
    #1;
    checks++;
    if (SAXI_awready !== 1'b1 || SAXI_arready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arb_second: awready=%b arready=%b, required 1 0", SAXI_awready, SAXI_arready);
    end
    @(posedge clock); #1 SAXI_awvalid = 1'b0;
    write_beats(4'hA, BASE_ADDR + 32'h38, 0, 3, 2'b01, 64'h0BAD_F00D_0000_0001, 8'hFF, 1'b0);
    collect_b();
    expect_read(4'h9, BASE_ADDR + 32'h38, 0, 3, 2'b01);
    n = 0;
    while (!SAXI_arready && n < TMO) begin @(negedge clock); n++; end
    checks++;
    if (!SAXI_arready) begin errors++; $display("[TB] FAIL arb_then_read: arready=%b, required 1", SAXI_arready); end
    @(posedge clock); #1 SAXI_arvalid = 1'b0;
    collect_r(0);
  endtask

  task automatic test_wrap();
    send_aw(4'hB, BASE_ADDR, 5, 3, 2'b01);
    write_beats(4'hB, BASE_ADDR, 5, 3, 2'b01, 64'h0101_0101_0101_0101, 8'hFF, 1'b0);
    collect_b();
    expect_read(4'hC, BASE_ADDR + 32'h10, 3, 3, 2'b10);
    send_ar(4'hC, BASE_ADDR + 32'h10, 3, 3, 2'b10);
    collect_r(0);
  endtask

  task automatic test_errors();
    expect_read(4'hD, BASE_ADDR, 1, 3, 2'b11);
    send_ar(4'hD, BASE_ADDR, 1, 3, 2'b11);
    collect_r(0);
    send_aw(4'hE, BASE_ADDR, 0, 4, 2'b01);
    write_beats(4'hE, BASE_ADDR, 0, 4, 2'b01, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b0);
    collect_b();
    send_aw(4'hF, BASE_ADDR + 32'h8, 1, 3, 2'b01);
    write_beats(4'hF, BASE_ADDR + 32'h8, 1, 3, 2'b01, 64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    collect_b();
    expect_read(4'h0, BASE_ADDR, 2, 3, 2'b01);
    send_ar(4'h0, BASE_ADDR, 2, 3, 2'b01);
    collect_r(0);
  endtask

  initial begin
    test_reset();
    test_incr_burst();
    test_strobe();
    test_out_of_range();
    test_mid_burst_reset();
    test_arbitration();
    test_wrap();
    test_errors();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
